fifo_stack_ctrl: RTL and testbench
==================================

// Module: fifo_stack_ctrl
// PURPOSE
//  Sequencer/arbiter in front of fifo_stack in the USB3300 parser. Shares the stack write
//  port between two byte sources (A: parsed ULPI data, B: marker/status bytes) with
//  round-robin grant. Drains the stack into the UART transmitter one byte per TX_busy cycle.
//  Tracks occupancy internally; the stack's FIFO_full/FIFO_empty flags are not used.
// PARAMETERS
//  STACK_SIZE   15  stack depth in entries; must match the fifo_stack instance
//  STACK_WIDTH  8   data width of sources, stack and UART
//  ACK_TIMEOUT  16  max cycles from TX_start to TX_busy rising before abort
// PORTS
//  clk          in   1   master clock
//  rst          in   1   synchronous, active-high reset
//  A_valid      in   1   source A has a byte; held until A_ack
//  A_data       in   W   source A byte
//  A_ack        out  1   1-cycle pulse: A_data written this cycle
//  B_valid      in   1   source B has a byte; held until B_ack
//  B_data       in   W   source B byte
//  B_ack        out  1   1-cycle pulse: B_data written this cycle
//  flush        in   1   1-cycle request to discard all stack contents
//  FIFO_I_DATA  out  W   to stack I_DATA (combinational mux of granted source)
//  FIFO_save    out  1   to stack FIFO_save (combinational, = A_ack|B_ack)
//  FIFO_pop     out  1   to stack FIFO_pop (registered pulse)
//  FIFO_reset   out  1   to stack FIFO_reset (registered)
//  FIFO_O_DATA  in   W   stack head entry
//  TX_data      out  W   UART byte, registered, stable until next TX_start
//  TX_start     out  1   1-cycle UART start pulse
//  TX_busy      in   1   UART busy
//  count        out  clog2(STACK_SIZE+1)  current occupancy
//  err_timeout  out  1   sticky: TX_busy never rose within ACK_TIMEOUT
// BEHAVIOUR
//  Reset: FIFO_reset=1 for the reset cycle and the next; every other output 0; count=0;
//   state IDLE; RR pointer favours A.
//  Write grant, same cycle: grant only if count<STACK_SIZE and no flush/reset this cycle.
//   Only one source valid -> grant it. Both valid -> grant by RR pointer, then flip pointer.
//   Full -> no ack; sources hold their data and nothing is dropped.
//  Count, next edge: +1 on save only, -1 on pop only, unchanged on both, 0 on flush.
//   Never wraps: save is blocked at STACK_SIZE; pop is issued only when count>0.
//  Drain FSM:
//   IDLE: count>0 && !TX_busy -> SEND.
//   SEND (1 cycle): TX_data<=FIFO_O_DATA; TX_start=1; FIFO_pop=1; clear timer -> WAIT_ACK.
//   WAIT_ACK: TX_busy=1 -> WAIT_DONE.
//    Timer reaching ACK_TIMEOUT -> set err_timeout; go to IDLE. The byte is already popped
//    and is lost.
//   WAIT_DONE: TX_busy=0 -> IDLE.
//  Throughput: at most one byte per UART frame + 2 cycles; latency from first write to
//   TX_start = 2 cycles.
//  flush: FIFO_reset=1 next cycle; count=0; no grant in the flush cycle. FSM state is kept;
//   a byte already in the UART completes. A pending SEND is cancelled to IDLE. Flush does
//   not clear err_timeout; only rst does.
//  Save+pop in the same cycle is legal; the stack sees both.
//  Reset mid-transfer: FSM goes to IDLE at once; the UART frame in flight is not tracked.
// STRUCTURE
//  fifo_ctrl_defs.vh: FSM state localparams (IDLE/SEND/WAIT_ACK/WAIT_DONE) and count-width
//   macro, shared with testbench.
//  Sub-module fifo_wr_arbiter: 2-way round-robin grant, ack and data mux.
//  FSM, counter and timer stay in the top level.
// TESTING
//  1. rst high 2 cycles -> FIFO_reset=1 through cycle after rst; acks/TX_start/count=0.
//  2. A_valid with 0x41, UART idle -> A_ack, count=1; SEND 2 cycles later, TX_data=0x41,
//     FIFO_pop pulse; count=0.
//  3. A and B valid for 4 cycles with TX_busy held 1 -> acks alternate A,B,A,B; count=4.
//  4. Fill to 15 with TX_busy=1; A_valid=1 -> no A_ack, count=15. Release TX_busy ->
//     pop, then A_ack; count stays 15.
//  5. count=5, pulse flush with A_valid=1 -> no ack that cycle; FIFO_reset pulse; count=0.
//  6. TX_busy stuck 0 after TX_start -> after 16 cycles err_timeout=1, FSM IDLE, next byte sent.

Source files
------------

// File: rtl/fifo_stack_ctrl_pkg.sv
// Shared types and defaults for the fifo_stack write-arbiter / UART drain controller.
// Imported by the top, the arbiter and the testbench.
package fifo_stack_ctrl_pkg;

    localparam int unsigned DefStackSize  = 15;
    localparam int unsigned DefStackWidth = 8;
    localparam int unsigned DefAckTimeout = 16;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StSend     = 2'd1,
        StWaitAck  = 2'd2,
        StWaitDone = 2'd3
    } drain_state_e;

    // Width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_stack_ctrl_if.sv
// Handshake bundle between the controller, the two byte sources, the stack and the UART.
// master: the surrounding system (sources, stack, UART); slave: the controller.
interface fifo_stack_ctrl_if #(
    parameter int unsigned Width = 8
) ();

    logic             A_valid;
    logic [Width-1:0] A_data;
    logic             A_ack;
    logic             B_valid;
    logic [Width-1:0] B_data;
    logic             B_ack;

    logic [Width-1:0] FIFO_I_DATA;
    logic             FIFO_save;
    logic             FIFO_pop;
    logic             FIFO_reset;
    logic [Width-1:0] FIFO_O_DATA;

    logic [Width-1:0] TX_data;
    logic             TX_start;
    logic             TX_busy;

    modport master (
        output A_valid, A_data, B_valid, B_data, FIFO_O_DATA, TX_busy,
        input  A_ack, B_ack, FIFO_I_DATA, FIFO_save, FIFO_pop, FIFO_reset, TX_data, TX_start
    );

    modport slave (
        input  A_valid, A_data, B_valid, B_data, FIFO_O_DATA, TX_busy,
        output A_ack, B_ack, FIFO_I_DATA, FIFO_save, FIFO_pop, FIFO_reset, TX_data, TX_start
    );

endinterface

// File: rtl/fifo_stack_ctrl_wr_arbiter.sv
// Two-way round-robin arbiter for the stack write port: same-cycle ack and data mux.
// The pointer only flips when both sources compete and one of them is granted.
module fifo_stack_ctrl_wr_arbiter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             a_valid_i,
    input  logic [Width-1:0] a_data_i,
    input  logic             b_valid_i,
    input  logic [Width-1:0] b_data_i,
    output logic             a_ack_o,
    output logic             b_ack_o,
    output logic             save_o,
    output logic [Width-1:0] wr_data_o
);

    // 0: A wins the next tie, 1: B wins the next tie.
    logic rr_q, rr_d;

    always_comb begin
        a_ack_o = 1'b0;
        b_ack_o = 1'b0;
        rr_d    = rr_q;
        if (en_i) begin
            if (a_valid_i && b_valid_i) begin
                if (rr_q) begin
                    b_ack_o = 1'b1;
                end else begin
                    a_ack_o = 1'b1;
                end
                rr_d = ~rr_q;
            end else if (a_valid_i) begin
                a_ack_o = 1'b1;
            end else if (b_valid_i) begin
                b_ack_o = 1'b1;
            end
        end
    end

    assign save_o    = a_ack_o | b_ack_o;
    assign wr_data_o = b_ack_o ? b_data_i : a_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/fifo_stack_ctrl.sv
// Front-end sequencer for fifo_stack: arbitrates two byte sources onto the stack write port,
// tracks occupancy and drains the stack into a UART one byte per frame with an ack timeout.
module fifo_stack_ctrl
    import fifo_stack_ctrl_pkg::*;
#(
    parameter int unsigned StackSize  = DefStackSize,
    parameter int unsigned StackWidth = DefStackWidth,
    parameter int unsigned AckTimeout = DefAckTimeout,
    localparam int unsigned CntW      = cnt_width(StackSize)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    fifo_stack_ctrl_if.slave    bus,
    output logic [CntW-1:0]     count,
    output logic                err_timeout
);

    localparam int unsigned TimerW = $clog2(AckTimeout + 1);

    drain_state_e            state_q, state_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [TimerW-1:0]       timer_q, timer_d;
    logic                    err_q, err_d;
    logic [StackWidth-1:0]   tx_data_q, tx_data_d;
    logic                    tx_start_q, tx_start_d;
    logic                    fifo_reset_q, fifo_reset_d;
    logic                    rst_hold_q;

    logic                    wr_en;
    logic                    a_ack, b_ack, save, pop;
    logic [StackWidth-1:0]   wr_data;

    // No writes while full, flushing or in reset.
    assign wr_en = (count_q < CntW'(StackSize)) && !flush && !rst;

    fifo_stack_ctrl_wr_arbiter #(
        .Width (StackWidth)
    ) u_wr_arbiter (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (wr_en),
        .a_valid_i (bus.A_valid),
        .a_data_i  (bus.A_data),
        .b_valid_i (bus.B_valid),
        .b_data_i  (bus.B_data),
        .a_ack_o   (a_ack),
        .b_ack_o   (b_ack),
        .save_o    (save),
        .wr_data_o (wr_data)
    );

    // TX_start and FIFO_pop share one flop: both pulse for the single SEND cycle.
    assign pop = tx_start_q;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (save && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !save) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        err_d      = err_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Head byte is latched on the way into SEND so TX_data is valid with TX_start.
                if ((count_q != '0) && !bus.TX_busy && !flush) begin
                    state_d    = StSend;
                    tx_start_d = 1'b1;
                    tx_data_d  = bus.FIFO_O_DATA;
                end
            end
            StSend: begin
                timer_d = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (bus.TX_busy) begin
                    state_d = StWaitDone;
                end else if (timer_q == TimerW'(AckTimeout - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!bus.TX_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stack reset is held one extra cycle after rst drops, and pulses after a flush.
    assign fifo_reset_d = flush | rst_hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            count_q      <= '0;
            timer_q      <= '0;
            err_q        <= 1'b0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            fifo_reset_q <= 1'b1;
            rst_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            fifo_reset_q <= fifo_reset_d;
            rst_hold_q   <= 1'b0;
        end
    end

    assign bus.A_ack       = a_ack;
    assign bus.B_ack       = b_ack;
    assign bus.FIFO_save   = save;
    assign bus.FIFO_I_DATA = wr_data;
    assign bus.FIFO_pop    = pop;
    assign bus.FIFO_reset  = fifo_reset_q;
    assign bus.TX_data     = tx_data_q;
    assign bus.TX_start    = tx_start_q;
    assign count           = count_q;
    assign err_timeout     = err_q;

    a_occ_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CntW'(StackSize));
    a_ack_excl: assert property (@(posedge clk) disable iff (rst)
        !(a_ack && b_ack));
    a_pop_nonempty: assert property (@(posedge clk) disable iff (rst)
        pop |-> (count_q != '0));

endmodule

// File: tb/tb_fifo_stack_ctrl.sv
// Directed bench for fifo_stack_ctrl: reset, arbitration, full stall, flush and ack timeout.
module tb_fifo_stack_ctrl;
    import fifo_stack_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [3:0] count;
    logic       err_timeout;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          found;

    fifo_stack_ctrl_if #(.Width(8)) bus ();

    fifo_stack_ctrl #(
        .StackSize  (15),
        .StackWidth (8),
        .AckTimeout (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .count       (count),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.A_valid     = 1'b0;
        bus.A_data      = '0;
        bus.B_valid     = 1'b0;
        bus.B_data      = '0;
        bus.FIFO_O_DATA = '0;
        bus.TX_busy     = 1'b0;

        // Reset held for two edges.
        step();
        step();
        settle();
        check_eq("rst_fifo_reset", bus.FIFO_reset, 1);
        check_eq("rst_count", count, 0);
        check_eq("rst_a_ack", bus.A_ack, 0);
        check_eq("rst_b_ack", bus.B_ack, 0);
        check_eq("rst_tx_start", bus.TX_start, 0);
        check_eq("rst_pop", bus.FIFO_pop, 0);
        check_eq("rst_err", err_timeout, 0);
        rst = 1'b0;
        step();
        settle();
        check_eq("rst_fifo_reset_hold", bus.FIFO_reset, 1);
        step();
        settle();
        check_eq("rst_fifo_reset_drop", bus.FIFO_reset, 0);

        // Single A byte drained to an idle UART.
        bus.A_valid = 1'b1;
        bus.A_data  = 8'h41;
        settle();
        check_eq("t2_a_ack", bus.A_ack, 1);
        check_eq("t2_save", bus.FIFO_save, 1);
        check_eq("t2_wdata", bus.FIFO_I_DATA, 8'h41);
        step();
        bus.A_valid     = 1'b0;
        bus.FIFO_O_DATA = 8'h41;
        settle();
        check_eq("t2_count1", count, 1);
        check_eq("t2_no_start_yet", bus.TX_start, 0);
        step();
        settle();
        check_eq("t2_tx_start", bus.TX_start, 1);
        check_eq("t2_pop", bus.FIFO_pop, 1);
        check_eq("t2_tx_data", bus.TX_data, 8'h41);
        check_eq("t2_count_send", count, 1);
        step();
        bus.TX_busy = 1'b1;
        settle();
        check_eq("t2_count0", count, 0);
        check_eq("t2_start_drop", bus.TX_start, 0);
        check_eq("t2_pop_drop", bus.FIFO_pop, 0);

        // Both sources valid: strict alternation starting with A.
        bus.A_valid = 1'b1;
        bus.A_data  = 8'h11;
        bus.B_valid = 1'b1;
        bus.B_data  = 8'h22;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("t3_a_ack%0d", i), bus.A_ack, (i % 2 == 0) ? 1 : 0);
            check_eq($sformatf("t3_b_ack%0d", i), bus.B_ack, (i % 2 == 1) ? 1 : 0);
            check_eq($sformatf("t3_wdata%0d", i), bus.FIFO_I_DATA,
                     (i % 2 == 0) ? 8'h11 : 8'h22);
            step();
        end
        bus.A_valid = 1'b0;
        bus.B_valid = 1'b0;
        settle();
        check_eq("t3_count4", count, 4);
        step();

        // Fill to capacity with the UART busy, then stall.
        bus.A_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bus.A_data = 8'(8'h60 + i);
            settle();
            check_eq($sformatf("t4_fill_ack%0d", i), bus.A_ack, 1);
            step();
        end
        settle();
        check_eq("t4_full_count", count, 15);
        check_eq("t4_full_no_ack", bus.A_ack, 0);
        check_eq("t4_full_no_save", bus.FIFO_save, 0);
        step();
        bus.TX_busy     = 1'b0;
        bus.FIFO_O_DATA = 8'h5A;
        settle();
        check_eq("t4_hold_no_ack", bus.A_ack, 0);
        step();
        settle();
        check_eq("t4_idle_no_start", bus.TX_start, 0);
        check_eq("t4_idle_no_ack", bus.A_ack, 0);
        step();
        settle();
        check_eq("t4_send_start", bus.TX_start, 1);
        check_eq("t4_send_pop", bus.FIFO_pop, 1);
        check_eq("t4_send_data", bus.TX_data, 8'h5A);
        check_eq("t4_send_no_ack", bus.A_ack, 0);
        step();
        bus.TX_busy = 1'b1;
        settle();
        check_eq("t4_after_pop_count", count, 14);
        check_eq("t4_after_pop_ack", bus.A_ack, 1);
        step();
        settle();
        check_eq("t4_refill_count", count, 15);
        check_eq("t4_refill_no_ack", bus.A_ack, 0);

        // Flush at full, refill to 5, flush again with A pending.
        flush = 1'b1;
        settle();
        check_eq("t5_flush_no_ack", bus.A_ack, 0);
        check_eq("t5_flush_no_save", bus.FIFO_save, 0);
        step();
        flush = 1'b0;
        settle();
        check_eq("t5_flush_count", count, 0);
        check_eq("t5_flush_reset", bus.FIFO_reset, 1);
        for (int i = 0; i < 5; i++) begin
            settle();
            check_eq($sformatf("t5_refill_ack%0d", i), bus.A_ack, 1);
            step();
        end
        flush = 1'b1;
        settle();
        check_eq("t5_count5", count, 5);
        check_eq("t5_flush2_no_ack", bus.A_ack, 0);
        step();
        flush       = 1'b0;
        bus.A_valid = 1'b0;
        settle();
        check_eq("t5_flush2_reset", bus.FIFO_reset, 1);
        check_eq("t5_flush2_count", count, 0);
        step();
        settle();
        check_eq("t5_reset_drop", bus.FIFO_reset, 0);
        check_eq("t5_err_clear", err_timeout, 0);

        // UART never acknowledges: timeout after 16 WAIT_ACK cycles.
        bus.A_valid = 1'b1;
        bus.A_data  = 8'h77;
        settle();
        check_eq("t6_a_ack", bus.A_ack, 1);
        step();
        bus.A_valid     = 1'b0;
        bus.TX_busy     = 1'b0;
        bus.FIFO_O_DATA = 8'h77;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            step();
            settle();
            if (bus.TX_start === 1'b1) found = 1'b1;
        end
        check_eq("t6_start_seen", found, 1);
        check_eq("t6_tx_data", bus.TX_data, 8'h77);
        step();
        bus.B_valid = 1'b1;
        bus.B_data  = 8'h99;
        settle();
        check_eq("t6_b_ack", bus.B_ack, 1);
        step();
        bus.B_valid     = 1'b0;
        bus.FIFO_O_DATA = 8'h99;
        for (int k = 0; k < 14; k++) step();
        settle();
        check_eq("t6_err_not_yet", err_timeout, 0);
        step();
        settle();
        check_eq("t6_err_set", err_timeout, 1);
        check_eq("t6_no_start", bus.TX_start, 0);
        step();
        settle();
        check_eq("t6_next_start", bus.TX_start, 1);
        check_eq("t6_next_data", bus.TX_data, 8'h99);
        step();
        bus.TX_busy = 1'b1;
        settle();
        check_eq("t6_count0", count, 0);
        check_eq("t6_err_sticky", err_timeout, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        settle();
        check_eq("t6_flush_keeps_err", err_timeout, 1);
        check_eq("t6_flush_reset", bus.FIFO_reset, 1);

        // Reset mid-transfer clears the sticky error.
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check_eq("t7_err_cleared", err_timeout, 0);
        check_eq("t7_count", count, 0);
        check_eq("t7_tx_start", bus.TX_start, 0);
        check_eq("t7_fifo_reset", bus.FIFO_reset, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
